stat_sequencer: RTL and testbench

Clocked controller that owns one combinational stat_calculator instance and sequences it. It accepts four 4-bit samples over a valid/ready stream and presents them to the calculator. It then steps the calculator's op code through MAX, MIN, MEAN and VAR, captures each 8-bit result, and returns all four results as one batch over a valid/ready output handshake. It sits between the sample source and any consumer of the statistics.

---
 rtl/stat_pkg.sv | 33 +++
 rtl/stat_sequencer_if.sv | 27 ++
 rtl/stat_sequencer.sv | 121 ++++++++++++
 tb/tb_stat_sequencer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stat_pkg.sv
// Shared types and constants for the statistics sequencer: op codes, FSM states
// and the one-hot flag each op is expected to raise on the calculator.
package stat_pkg;

    localparam int N_SAMPLES = 4;

    typedef enum logic [3:0] {
        OP_IDLE = 4'b0000,
        OP_MAX  = 4'b1000,
        OP_MIN  = 4'b1100,
        OP_MEAN = 4'b1010,
        OP_VAR  = 4'b1111
    } op_e;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Ops are issued in this order; EXP_FLAGS shares the same index.
    localparam op_e OP_TABLE [N_SAMPLES] = '{OP_MAX, OP_MIN, OP_MEAN, OP_VAR};
    localparam logic [3:0] EXP_FLAGS [N_SAMPLES] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

    function automatic logic [3:0] exp_flag(input logic [1:0] idx);
        return EXP_FLAGS[idx];
    endfunction

    function automatic op_e op_at(input logic [1:0] idx);
        return OP_TABLE[idx];
    endfunction

endpackage

// File: rtl/stat_sequencer_if.sv
// Sample stream in, result batch out. The master side is the sample source and
// result consumer; the slave side is the sequencer.
interface stat_sequencer_if;
    import stat_pkg::*;

    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] res_max;
    logic [7:0] res_min;
    logic [7:0] res_mean;
    logic [7:0] res_var;
    logic       flag_err;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, res_max, res_min, res_mean, res_var, flag_err
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, res_max, res_min, res_mean, res_var, flag_err
    );

endinterface

// File: rtl/stat_sequencer.sv
// Loads four samples, steps an external combinational calculator through
// MAX/MIN/MEAN/VAR, captures each result and hands the batch out on a handshake.
module stat_sequencer
    import stat_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    stat_sequencer_if.slave   bus,
    output logic [15:0]       calc_nums,
    output logic [3:0]        calc_op,
    input  logic [3:0]        calc_flags,
    input  logic [7:0]        calc_result
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [1:0] LAST_SLOT   = 2'(N_SAMPLES - 1);

    seq_state_e  state_r;
    logic [1:0]  cnt_r;
    logic [1:0]  idx_r;
    logic [3:0]  settle_r;
    logic [15:0] nums_r;
    op_e         op_r;
    logic [7:0]  res_max_r;
    logic [7:0]  res_min_r;
    logic [7:0]  res_mean_r;
    logic [7:0]  res_var_r;
    logic        out_valid_r;
    logic        flag_err_r;

    // Sequencer FSM: sample loading, op stepping with result capture, batch handoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= LOAD;
            cnt_r       <= 2'd0;
            idx_r       <= 2'd0;
            settle_r    <= 4'd0;
            nums_r      <= 16'd0;
            op_r        <= OP_IDLE;
            res_max_r   <= 8'd0;
            res_min_r   <= 8'd0;
            res_mean_r  <= 8'd0;
            res_var_r   <= 8'd0;
            out_valid_r <= 1'b0;
            flag_err_r  <= 1'b0;
        end else begin
            case (state_r)
                LOAD: begin
                    if (bus.in_valid) begin
                        // Slot 1 (first accepted) lives in the top nibble.
                        case (cnt_r)
                            2'd0:    nums_r[15:12] <= bus.in_data;
                            2'd1:    nums_r[11:8]  <= bus.in_data;
                            2'd2:    nums_r[7:4]   <= bus.in_data;
                            default: nums_r[3:0]   <= bus.in_data;
                        endcase
                        if (cnt_r == LAST_SLOT) begin
                            cnt_r    <= 2'd0;
                            idx_r    <= 2'd0;
                            settle_r <= 4'd0;
                            op_r     <= op_at(2'd0);
                            state_r  <= RUN;
                        end else begin
                            cnt_r <= cnt_r + 2'd1;
                        end
                    end
                end
                RUN: begin
                    if (settle_r == SETTLE_LAST) begin
                        case (idx_r)
                            2'd0:    res_max_r  <= calc_result;
                            2'd1:    res_min_r  <= calc_result;
                            2'd2:    res_mean_r <= calc_result;
                            default: res_var_r  <= calc_result;
                        endcase
                        if (calc_flags != exp_flag(idx_r)) begin
                            flag_err_r <= 1'b1;
                        end
                        settle_r <= 4'd0;
                        if (idx_r == LAST_SLOT) begin
                            idx_r       <= 2'd0;
                            op_r        <= OP_IDLE;
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            idx_r <= idx_r + 2'd1;
                            op_r  <= op_at(idx_r + 2'd1);
                        end
                    end else begin
                        settle_r <= settle_r + 4'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        flag_err_r  <= 1'b0;
                        state_r     <= LOAD;
                    end
                end
                default: begin
                    state_r     <= LOAD;
                    op_r        <= OP_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_r == LOAD);
    assign bus.out_valid = out_valid_r;
    assign bus.res_max   = res_max_r;
    assign bus.res_min   = res_min_r;
    assign bus.res_mean  = res_mean_r;
    assign bus.res_var   = res_var_r;
    assign bus.flag_err  = flag_err_r;
    assign calc_nums     = nums_r;
    assign calc_op       = op_r;

endmodule

// File: tb/tb_stat_sequencer.sv
// Self-checking bench: two sequencers (settle 1 and 3) each driving a behavioural
// calculator model; expectations come from the sample list, not the DUT.
module tb_stat_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic sel = 1'b0;
    logic in_valid = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic out_ready = 1'b0;
    logic force_err = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    int smp [4];

    logic [15:0] c1_nums, c3_nums;
    logic [3:0]  c1_op, c3_op, c1_flags, c3_flags;
    logic [7:0]  c1_res, c3_res;

    stat_sequencer_if bus1 ();
    stat_sequencer_if bus3 ();

    assign bus1.in_valid  = in_valid & ~sel;
    assign bus1.in_data   = in_data;
    assign bus1.out_ready = out_ready & ~sel;
    assign bus3.in_valid  = in_valid & sel;
    assign bus3.in_data   = in_data;
    assign bus3.out_ready = out_ready & sel;

    stat_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .calc_nums(c1_nums),
        .calc_op(c1_op), .calc_flags(c1_flags), .calc_result(c1_res));

    stat_sequencer #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave), .calc_nums(c3_nums),
        .calc_op(c3_op), .calc_flags(c3_flags), .calc_result(c3_res));

    logic       in_ready_m, out_valid_m, flag_err_m;
    logic [7:0] res_max_m, res_min_m, res_mean_m, res_var_m;
    logic [3:0] calc_op_m;
    logic [15:0] calc_nums_m;
    assign in_ready_m  = sel ? bus3.in_ready  : bus1.in_ready;
    assign out_valid_m = sel ? bus3.out_valid : bus1.out_valid;
    assign flag_err_m  = sel ? bus3.flag_err  : bus1.flag_err;
    assign res_max_m   = sel ? bus3.res_max   : bus1.res_max;
    assign res_min_m   = sel ? bus3.res_min   : bus1.res_min;
    assign res_mean_m  = sel ? bus3.res_mean  : bus1.res_mean;
    assign res_var_m   = sel ? bus3.res_var   : bus1.res_var;
    assign calc_op_m   = sel ? c3_op   : c1_op;
    assign calc_nums_m = sel ? c3_nums : c1_nums;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // which: 0=max 1=min 2=mean 3=var
    function automatic int ref_stat(input int which, input int s [4]);
        int mx = s[0];
        int mn = s[0];
        int sum = 0;
        int mean;
        int acc = 0;
        for (int i = 0; i < 4; i++) begin
            if (s[i] > mx) mx = s[i];
            if (s[i] < mn) mn = s[i];
            sum += s[i];
        end
        mean = sum / 4;
        for (int i = 0; i < 4; i++) acc += (s[i] - mean) * (s[i] - mean);
        case (which)
            0: return mx;
            1: return mn;
            2: return mean;
            default: return acc / 4;
        endcase
    endfunction

    function automatic logic [7:0] model_result(input logic [3:0] op, input logic [15:0] nums);
        int s [4];
        for (int i = 0; i < 4; i++) s[i] = int'(nums[(3 - i) * 4 +: 4]);
        case (op)
            4'b1000: return 8'(ref_stat(0, s));
            4'b1100: return 8'(ref_stat(1, s));
            4'b1010: return 8'(ref_stat(2, s));
            4'b1111: return 8'(ref_stat(3, s));
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [3:0] model_flags(input logic [3:0] op);
        case (op)
            4'b1000: return 4'b1000;
            4'b1100: return 4'b0100;
            4'b1010: return 4'b0010;
            4'b1111: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    always_comb begin
        c1_res   = model_result(c1_op, c1_nums);
        c1_flags = model_flags(c1_op);
        if (force_err && c1_op == 4'b1000) c1_flags = 4'b0100;
        c3_res   = model_result(c3_op, c3_nums);
        c3_flags = model_flags(c3_op);
        if (force_err && c3_op == 4'b1000) c3_flags = 4'b0100;
    end

    task automatic load_batch(input bit toggle);
        int k = 0;
        int guard = 0;
        bit ph = 1'b1;
        while (k < 4 && guard < 100) begin
            @(negedge clk);
            guard++;
            in_valid = toggle ? ph : 1'b1;
            ph = ~ph;
            in_data = 4'(smp[k]);
            if (in_valid && in_ready_m) begin
                if (k == 0) first_cyc = cyc;
                last_cyc = cyc;
                k++;
            end
        end
        total++;
        if (k != 4) begin
            bad++;
            $display("FAIL load_batch: accepted %0d samples, required 4", k);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int m);
        int g = 0;
        m = -1;
        while (g < 200) begin
            @(negedge clk);
            g++;
            if (out_valid_m) begin
                m = cyc;
                break;
            end
        end
        total++;
        if (m < 0) begin
            bad++;
            $display("FAIL wait_out: out_valid never rose within 200 cycles");
        end
    endtask

    task automatic take_batch();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid_m !== 1'b0 || flag_err_m !== 1'b0 || in_ready_m !== 1'b1) begin
            bad++;
            $display("FAIL take_batch: out_valid=%b flag_err=%b in_ready=%b, required 0 0 1",
                     out_valid_m, flag_err_m, in_ready_m);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total++;
        if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0 || flag_err_m !== 1'b0 ||
            calc_op_m !== 4'b0000 || calc_nums_m !== 16'h0000 ||
            {res_max_m, res_min_m, res_mean_m, res_var_m} !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: rdy=%b ov=%b err=%b op=%b nums=%h res=%h,%h,%h,%h",
                     in_ready_m, out_valid_m, flag_err_m, calc_op_m, calc_nums_m,
                     res_max_m, res_min_m, res_mean_m, res_var_m);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int m;
        logic [7:0] got [4];
        smp = '{13, 2, 0, 7};
        load_batch(1'b0);
        total++;
        if (calc_nums_m !== 16'hD207) begin
            bad++;
            $display("FAIL basic_nums: got %h required d207", calc_nums_m);
        end
        wait_out(m);
        total++;
        if (m - first_cyc != 8) begin
            bad++;
            $display("FAIL basic_latency: got %0d required 8", m - first_cyc);
        end
        got = '{res_max_m, res_min_m, res_mean_m, res_var_m};
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got[i] !== 8'(ref_stat(i, smp))) begin
                bad++;
                $display("FAIL basic_res%0d: got %0d required %0d", i, got[i], ref_stat(i, smp));
            end
        end
        total++;
        if (flag_err_m !== 1'b0) begin
            bad++;
            $display("FAIL basic_flag_err: got %b required 0", flag_err_m);
        end
        take_batch();
    endtask

    task automatic test_backpressure();
        int m;
        smp = '{15, 15, 15, 15};
        load_batch(1'b0);
        wait_out(m);
        in_valid = 1'b1;
        in_data = 4'd9;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (out_valid_m !== 1'b1 || in_ready_m !== 1'b0 || calc_nums_m !== 16'hFFFF ||
                {res_max_m, res_min_m, res_mean_m, res_var_m} !== {8'd15, 8'd15, 8'd15, 8'd0}) begin
                bad++;
                $display("FAIL stall_c%0d: ov=%b rdy=%b nums=%h res=%0d,%0d,%0d,%0d required 1 0 ffff 15,15,15,0",
                         i, out_valid_m, in_ready_m, calc_nums_m,
                         res_max_m, res_min_m, res_mean_m, res_var_m);
            end
        end
        in_valid = 1'b0;
        take_batch();
    endtask

    task automatic test_toggle_ops();
        logic [3:0] exp_op [4];
        exp_op = '{4'b1000, 4'b1100, 4'b1010, 4'b1111};
        smp = '{1, 2, 3, 6};
        @(negedge clk);
        total++;
        if (calc_op_m !== 4'b0000) begin
            bad++;
            $display("FAIL load_op: got %b required 0000", calc_op_m);
        end
        load_batch(1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (calc_op_m !== exp_op[i] || out_valid_m !== 1'b0) begin
                bad++;
                $display("FAIL op_seq%0d: op=%b ov=%b required %b 0", i, calc_op_m, out_valid_m, exp_op[i]);
            end
        end
        @(negedge clk);
        total++;
        if (out_valid_m !== 1'b1 || calc_op_m !== 4'b0000 ||
            {res_max_m, res_min_m, res_mean_m, res_var_m} !== {8'd6, 8'd1, 8'd3, 8'd3}) begin
            bad++;
            $display("FAIL toggle_done: ov=%b op=%b res=%0d,%0d,%0d,%0d required 1 0000 6,1,3,3",
                     out_valid_m, calc_op_m, res_max_m, res_min_m, res_mean_m, res_var_m);
        end
        take_batch();
    endtask

    task automatic test_flag_err();
        int m;
        force_err = 1'b1;
        for (int i = 0; i < 4; i++) smp[i] = int'($urandom_range(0, 15));
        load_batch(1'b0);
        wait_out(m);
        total++;
        if (flag_err_m !== 1'b1 || res_max_m !== 8'(ref_stat(0, smp))) begin
            bad++;
            $display("FAIL flag_err_set: err=%b max=%0d required 1 %0d", flag_err_m, res_max_m, ref_stat(0, smp));
        end
        force_err = 1'b0;
        take_batch();
        smp = '{9, 4, 11, 2};
        load_batch(1'b0);
        wait_out(m);
        total++;
        if (flag_err_m !== 1'b0 || res_var_m !== 8'(ref_stat(3, smp))) begin
            bad++;
            $display("FAIL flag_err_clean: err=%b var=%0d required 0 %0d", flag_err_m, res_var_m, ref_stat(3, smp));
        end
        take_batch();
    endtask

    task automatic test_async_reset();
        int m;
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 4'd7;
        @(negedge clk);
        in_data = 4'd8;
        @(posedge clk);
        #3 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        total++;
        if (calc_nums_m !== 16'h0000 || in_ready_m !== 1'b1 || calc_op_m !== 4'b0000 ||
            {res_max_m, res_min_m, res_mean_m, res_var_m} !== 32'h0) begin
            bad++;
            $display("FAIL async_reset: nums=%h rdy=%b op=%b res=%h,%h,%h,%h required 0000 1 0000 0",
                     calc_nums_m, in_ready_m, calc_op_m, res_max_m, res_min_m, res_mean_m, res_var_m);
        end
        @(negedge clk);
        rst_n = 1'b1;
        smp = '{1, 2, 3, 6};
        load_batch(1'b0);
        wait_out(m);
        total++;
        if (calc_nums_m !== 16'h1236 ||
            {res_max_m, res_min_m, res_mean_m, res_var_m} !== {8'd6, 8'd1, 8'd3, 8'd3}) begin
            bad++;
            $display("FAIL post_reset_batch: nums=%h res=%0d,%0d,%0d,%0d required 1236 6,1,3,3",
                     calc_nums_m, res_max_m, res_min_m, res_mean_m, res_var_m);
        end
        take_batch();
    endtask

    task automatic test_random();
        int m;
        int stall;
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 4; i++) smp[i] = int'($urandom_range(0, 15));
            load_batch(1'($urandom_range(0, 1)));
            wait_out(m);
            stall = int'($urandom_range(0, 4));
            repeat (stall) @(negedge clk);
            total++;
            if (out_valid_m !== 1'b1 ||
                {res_max_m, res_min_m, res_mean_m, res_var_m} !==
                {8'(ref_stat(0, smp)), 8'(ref_stat(1, smp)), 8'(ref_stat(2, smp)), 8'(ref_stat(3, smp))}) begin
                bad++;
                $display("FAIL random_b%0d: ov=%b res=%0d,%0d,%0d,%0d required 1 %0d,%0d,%0d,%0d", b,
                         out_valid_m, res_max_m, res_min_m, res_mean_m, res_var_m,
                         ref_stat(0, smp), ref_stat(1, smp), ref_stat(2, smp), ref_stat(3, smp));
            end
            take_batch();
        end
    endtask

    task automatic test_settle3();
        int held [4];
        int run = 0;
        int g = 0;
        held = '{0, 0, 0, 0};
        sel = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        smp = '{13, 2, 0, 7};
        load_batch(1'b0);
        while (g < 100) begin
            @(negedge clk);
            g++;
            if (out_valid_m) break;
            run++;
            case (calc_op_m)
                4'b1000: held[0]++;
                4'b1100: held[1]++;
                4'b1010: held[2]++;
                4'b1111: held[3]++;
                default: ;
            endcase
        end
        total++;
        if (out_valid_m !== 1'b1 || run != 12) begin
            bad++;
            $display("FAIL settle3_run: ov=%b run_cycles=%0d required 1 12", out_valid_m, run);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (held[i] != 3) begin
                bad++;
                $display("FAIL settle3_hold%0d: got %0d required 3", i, held[i]);
            end
        end
        total++;
        if ({res_max_m, res_min_m, res_mean_m, res_var_m} !== {8'd13, 8'd0, 8'd5, 8'd25} ||
            flag_err_m !== 1'b0) begin
            bad++;
            $display("FAIL settle3_res: res=%0d,%0d,%0d,%0d err=%b required 13,0,5,25 0",
                     res_max_m, res_min_m, res_mean_m, res_var_m, flag_err_m);
        end
        take_batch();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_toggle_ops();
        test_flag_err();
        test_async_reset();
        test_random();
        test_settle3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
